c499_key_loader: RTL and testbench
==================================

// Module: c499_key_loader
// PURPOSE
//  Upstream key-delivery stage for the key-locked c499 SEC core. Accepts key bits
//  one at a time from the secure key store over a valid/ready handshake, followed by
//  one even-parity bit. Once parity checks, it holds the key on key_out, which drives
//  the core's s_0..s_(KEY_WIDTH-1) inputs. Until a key is validated, key_out is forced
//  to all-zero, so the core never sees a partial or corrupt key.
// PARAMETERS
//  KEY_WIDTH  2  number of key bits; key_out[i] drives core input s_i
//  TIMEOUT    8  max consecutive idle cycles in SHIFT before abort; must be >= 2
// PORTS
//  clk            in   1          single clock; all state updates on rising edge
//  rst_n          in   1          asynchronous, active-low reset
//  load_start     in   1          1-cycle pulse that starts or restarts a key load
//  key_bit_in     in   1          serial key/parity bit from the key store
//  key_bit_valid  in   1          key_bit_in is valid
//  key_bit_ready  out  1          loader accepts a bit this cycle
//  key_out        out  KEY_WIDTH  validated key to the c499 core; 0 unless key_valid
//  key_valid      out  1          key_out holds a parity-checked key
//  key_err        out  1          last load failed (parity error or timeout)
//  busy           out  1          load in progress (state SHIFT or CHECK)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; key_out=0; key_valid=0; key_err=0; busy=0;
//   key_bit_ready=0; shift reg, bit count and idle count cleared. Outputs are registered.
//  States: IDLE, SHIFT, CHECK, LOCKED, ERROR.
//  Accept = key_bit_valid & key_bit_ready. key_bit_ready=1 only in SHIFT.
//  IDLE/LOCKED/ERROR + load_start -> SHIFT at next edge; at that edge: key_out=0,
//   key_valid=0, key_err=0, bit count=0, idle count=0, shift reg=0.
//  SHIFT: accepts KEY_WIDTH key bits. Each key bit shifts in as
//   sreg <= {bit, sreg[KEY_WIDTH-1:1]}, so the first bit lands in sreg[0] (s_0).
//   The (KEY_WIDTH+1)th accepted bit is the parity bit, is latched separately,
//   and moves the FSM to CHECK.
//  Idle count: cleared on every accept, else +1 per SHIFT cycle. If it is TIMEOUT-1
//   and the cycle has no accept -> ERROR (key_err=1 at that edge).
//  CHECK (exactly 1 cycle, ready=0): ok = ^sreg ^ parity == 0 (even parity).
//   ok -> LOCKED: key_out<=sreg, key_valid<=1. Fail -> ERROR: key_err<=1, key_out=0.
//   key_valid therefore rises 2 edges after the edge that accepts the parity bit.
//  LOCKED: holds key_out and key_valid until load_start or reset; key_bit_valid ignored.
//  ERROR: key_out=0, key_valid=0, key_err=1 until load_start or reset.
//  load_start during SHIFT/CHECK: restarts the load, with the same clears as above;
//   state stays/returns to SHIFT.
//  load_start on the same cycle as an accept in SHIFT: load_start wins and the bit
//   is discarded.
//  Reset mid-load: immediate return to reset values; no partial key is ever driven.
//  Counters sized $clog2(KEY_WIDTH+1) and $clog2(TIMEOUT); no wrap is reachable.
// TESTING (KEY_WIDTH=2, TIMEOUT=8)
//  1 Assert rst_n=0 in any state -> all outputs 0 immediately, state IDLE.
//  2 load_start; bits 1,0 then parity 1 -> 2 edges after parity accept:
//    key_out=2'b01, key_valid=1, key_err=0, busy=0.
//  3 load_start; bits 1,1 then parity 1 -> key_err=1, key_out=2'b00, key_valid=0.
//  4 load_start; one bit, then key_bit_valid=0 for 8 cycles -> key_err=1 on 8th idle edge.
//  5 From LOCKED (key 01), pulse load_start -> next edge key_valid=0, key_out=00,
//    ready=1; reload bits 0,1 with parity 1 -> key_out=2'b10.
//  6 Drop rst_n after 1 accepted bit, release, then full load of 1,1 with parity 0
//    -> key_out=2'b11, key_valid=1; also check load_start+accept collision drops the bit.

Source files
------------

// File: rtl/c499_key_loader.sv
// c499_key_loader: serial key delivery stage for the key-locked c499 SEC core.
// Key bits arrive one per accepted handshake and are followed by a single
// even-parity bit. A key reaches the core only after its parity checks.
// Until then key_out is held at zero, so the core never sees a partial or
// corrupt key.
module c499_key_loader #(
    parameter int KEY_WIDTH = 2,
    parameter int TIMEOUT   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_load_start,
    input  logic                 i_key_bit_in,
    input  logic                 i_key_bit_valid,
    output logic                 o_key_bit_ready,
    output logic [KEY_WIDTH-1:0] o_key_out,
    output logic                 o_key_valid,
    output logic                 o_key_err,
    output logic                 o_busy
);

    localparam int CW = $clog2(KEY_WIDTH + 1);
    localparam int IW = $clog2(TIMEOUT);

    // Bit-count value at which the next accepted bit is the parity bit.
    localparam logic [CW-1:0] LP_PARITY_SLOT = CW'(KEY_WIDTH);
    // Idle-count value at which one more idle cycle aborts the load.
    localparam logic [IW-1:0] LP_IDLE_LAST   = IW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_CHECK  = 3'd2,
        ST_LOCKED = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // Even parity over key and parity bit: the XOR of all of them must be 0.
    function automatic logic f_parity_ok(input logic [KEY_WIDTH-1:0] key,
                                         input logic par);
        return ~((^key) ^ par);
    endfunction

    state_t                 r_state;
    state_t                 w_next;
    logic [KEY_WIDTH-1:0]   r_sreg;
    logic                   r_parity;
    logic [CW-1:0]          r_bit_cnt;
    logic [IW-1:0]          r_idle_cnt;
    logic                   r_ready;
    logic                   r_busy;
    logic [KEY_WIDTH-1:0]   r_key_out;
    logic                   r_key_valid;
    logic                   r_key_err;

    logic                   w_accept;
    logic                   w_parity_slot;
    logic                   w_idle_expired;
    logic                   w_parity_ok;

    // Handshake qualifiers and checks used by both the FSM and the datapath.
    always_comb begin
        w_accept       = i_key_bit_valid & r_ready;
        w_parity_slot  = (r_bit_cnt == LP_PARITY_SLOT);
        w_idle_expired = (r_idle_cnt == LP_IDLE_LAST);
        w_parity_ok    = f_parity_ok(r_sreg, r_parity);
    end

    // Next-state decode; load_start restarts the load from any state.
    always_comb begin
        w_next = r_state;
        if (i_load_start) begin
            w_next = ST_SHIFT;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    if (w_accept) begin
                        if (w_parity_slot) begin
                            w_next = ST_CHECK;
                        end else begin
                            w_next = ST_SHIFT;
                        end
                    end else if (w_idle_expired) begin
                        w_next = ST_ERROR;
                    end else begin
                        w_next = ST_SHIFT;
                    end
                end
                ST_CHECK: begin
                    if (w_parity_ok) begin
                        w_next = ST_LOCKED;
                    end else begin
                        w_next = ST_ERROR;
                    end
                end
                ST_IDLE:   w_next = ST_IDLE;
                ST_LOCKED: w_next = ST_LOCKED;
                ST_ERROR:  w_next = ST_ERROR;
                default:   w_next = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Shift register, parity latch and the bit/idle counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sreg     <= '0;
            r_parity   <= 1'b0;
            r_bit_cnt  <= '0;
            r_idle_cnt <= '0;
        end else if (i_load_start) begin
            // A restart discards any bit offered in the same cycle.
            r_sreg     <= '0;
            r_parity   <= 1'b0;
            r_bit_cnt  <= '0;
            r_idle_cnt <= '0;
        end else if (r_state == ST_SHIFT) begin
            if (w_accept) begin
                r_idle_cnt <= '0;
                if (w_parity_slot) begin
                    r_parity <= i_key_bit_in;
                end else begin
                    // The first key bit ends up in sreg[0] (core input s_0).
                    r_sreg    <= {i_key_bit_in, r_sreg[KEY_WIDTH-1:1]};
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                end
            end else if (!w_idle_expired) begin
                r_idle_cnt <= r_idle_cnt + IW'(1);
            end else begin
                r_idle_cnt <= r_idle_cnt;
            end
        end else begin
            r_idle_cnt <= r_idle_cnt;
        end
    end

    // Registered outputs: handshake/busy follow the next state, key status follows the FSM.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_key_out   <= '0;
            r_key_valid <= 1'b0;
            r_key_err   <= 1'b0;
        end else begin
            r_ready <= (w_next == ST_SHIFT);
            r_busy  <= (w_next == ST_SHIFT) || (w_next == ST_CHECK);
            if (i_load_start) begin
                r_key_out   <= '0;
                r_key_valid <= 1'b0;
                r_key_err   <= 1'b0;
            end else begin
                case (r_state)
                    ST_SHIFT: begin
                        if (w_next == ST_ERROR) begin
                            r_key_err <= 1'b1;
                        end else begin
                            r_key_err <= 1'b0;
                        end
                    end
                    ST_CHECK: begin
                        if (w_parity_ok) begin
                            r_key_err <= 1'b0;
                        end else begin
                            r_key_err <= 1'b1;
                        end
                        r_key_out   <= '0;
                        r_key_valid <= 1'b0;
                    end
                    ST_LOCKED: begin
                        // The checked key is presented one edge after entering LOCKED.
                        r_key_out   <= r_sreg;
                        r_key_valid <= 1'b1;
                        r_key_err   <= 1'b0;
                    end
                    ST_ERROR: begin
                        r_key_out   <= '0;
                        r_key_valid <= 1'b0;
                        r_key_err   <= 1'b1;
                    end
                    default: begin
                        r_key_out   <= '0;
                        r_key_valid <= 1'b0;
                        r_key_err   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_key_bit_ready = r_ready;
    assign o_busy          = r_busy;
    assign o_key_out       = r_key_out;
    assign o_key_valid     = r_key_valid;
    assign o_key_err       = r_key_err;

endmodule

// File: tb/tb_c499_key_loader.sv
// Directed bench for c499_key_loader (KEY_WIDTH=2, TIMEOUT=8).
// Each table row gives the inputs for one clock cycle and the outputs
// expected just after the following rising edge.
module tb_c499_key_loader;

    logic       clk;
    logic       rst_n;
    logic       load_start;
    logic       key_bit_in;
    logic       key_bit_valid;
    logic       key_bit_ready;
    logic [1:0] key_out;
    logic       key_valid;
    logic       key_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       ls;
        logic       b;
        logic       v;
        logic       rdy;
        logic       bsy;
        logic [1:0] kout;
        logic       kv;
        logic       ke;
        string      name;
    } vec_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    c499_key_loader #(.KEY_WIDTH(2), .TIMEOUT(8)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_load_start    (load_start),
        .i_key_bit_in    (key_bit_in),
        .i_key_bit_valid (key_bit_valid),
        .o_key_bit_ready (key_bit_ready),
        .o_key_out       (key_out),
        .o_key_valid     (key_valid),
        .o_key_err       (key_err),
        .o_busy          (busy)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic ls, input logic b, input logic v,
                                input logic rdy, input logic bsy, input logic [1:0] kout,
                                input logic kv, input logic ke, input string name);
        vec_t r;
        r.ls = ls; r.b = b; r.v = v;
        r.rdy = rdy; r.bsy = bsy; r.kout = kout; r.kv = kv; r.ke = ke;
        r.name = name;
        return r;
    endfunction

    // Compare {ready, busy, key_out, key_valid, key_err} against the expectation.
    task automatic check(input string name, input logic [5:0] exp);
        logic [5:0] act;
        act = {key_bit_ready, busy, key_out, key_valid, key_err};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got rdy/busy/key/kv/err=%b required %b", name, act, exp);
        end
    endtask

    task automatic run_table(input vec_t t[$]);
        foreach (t[i]) begin
            load_start    = t[i].ls;
            key_bit_in    = t[i].b;
            key_bit_valid = t[i].v;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", t[i].name, i),
                  {t[i].rdy, t[i].bsy, t[i].kout, t[i].kv, t[i].ke});
        end
        load_start    = 1'b0;
        key_bit_valid = 1'b0;
        key_bit_in    = 1'b0;
    endtask

    initial begin
        // Key 01, ignored bit in LOCKED, reload to key 10.
        tbl_a.push_back(mk(1,0,0, 1,1,2'b00,0,0, "start"));
        tbl_a.push_back(mk(0,1,1, 1,1,2'b00,0,0, "k01_b0"));
        tbl_a.push_back(mk(0,0,1, 1,1,2'b00,0,0, "k01_b1"));
        tbl_a.push_back(mk(0,1,1, 0,1,2'b00,0,0, "k01_par"));
        tbl_a.push_back(mk(0,0,0, 0,0,2'b00,0,0, "k01_e1"));
        tbl_a.push_back(mk(0,0,0, 0,0,2'b01,1,0, "k01_lock"));
        tbl_a.push_back(mk(0,0,1, 0,0,2'b01,1,0, "locked_ign"));
        tbl_a.push_back(mk(1,0,0, 1,1,2'b00,0,0, "reload"));
        tbl_a.push_back(mk(0,0,1, 1,1,2'b00,0,0, "k10_b0"));
        tbl_a.push_back(mk(0,1,1, 1,1,2'b00,0,0, "k10_b1"));
        tbl_a.push_back(mk(0,1,1, 0,1,2'b00,0,0, "k10_par"));
        tbl_a.push_back(mk(0,0,0, 0,0,2'b00,0,0, "k10_e1"));
        tbl_a.push_back(mk(0,0,0, 0,0,2'b10,1,0, "k10_lock"));
        // Parity failure on key 11 with parity 1.
        tbl_a.push_back(mk(1,0,0, 1,1,2'b00,0,0, "perr_start"));
        tbl_a.push_back(mk(0,1,1, 1,1,2'b00,0,0, "perr_b0"));
        tbl_a.push_back(mk(0,1,1, 1,1,2'b00,0,0, "perr_b1"));
        tbl_a.push_back(mk(0,1,1, 0,1,2'b00,0,0, "perr_par"));
        tbl_a.push_back(mk(0,0,0, 0,0,2'b00,0,1, "perr_err"));
        tbl_a.push_back(mk(0,0,0, 0,0,2'b00,0,1, "perr_hold"));
        // Timeout: one bit, then eight idle cycles.
        tbl_a.push_back(mk(1,0,0, 1,1,2'b00,0,0, "to_start"));
        tbl_a.push_back(mk(0,1,1, 1,1,2'b00,0,0, "to_b0"));
        for (int i = 0; i < 7; i++)
            tbl_a.push_back(mk(0,0,0, 1,1,2'b00,0,0, "to_idle"));
        tbl_a.push_back(mk(0,0,0, 0,0,2'b00,0,1, "to_abort"));
        // Restart while in CHECK, then load key 10.
        tbl_a.push_back(mk(1,0,0, 1,1,2'b00,0,0, "rc_start"));
        tbl_a.push_back(mk(0,0,1, 1,1,2'b00,0,0, "rc_b0"));
        tbl_a.push_back(mk(0,0,1, 1,1,2'b00,0,0, "rc_b1"));
        tbl_a.push_back(mk(0,0,1, 0,1,2'b00,0,0, "rc_par"));
        tbl_a.push_back(mk(1,0,0, 1,1,2'b00,0,0, "rc_restart"));
        tbl_a.push_back(mk(0,0,1, 1,1,2'b00,0,0, "rc2_b0"));
        tbl_a.push_back(mk(0,1,1, 1,1,2'b00,0,0, "rc2_b1"));
        tbl_a.push_back(mk(0,1,1, 0,1,2'b00,0,0, "rc2_par"));
        tbl_a.push_back(mk(0,0,0, 0,0,2'b00,0,0, "rc2_e1"));
        tbl_a.push_back(mk(0,0,0, 0,0,2'b10,1,0, "rc2_lock"));

        // After reset: start, collision (bit dropped), key 11 with parity 0.
        tbl_b.push_back(mk(1,0,0, 1,1,2'b00,0,0, "col_start"));
        tbl_b.push_back(mk(1,0,1, 1,1,2'b00,0,0, "col_drop"));
        tbl_b.push_back(mk(0,1,1, 1,1,2'b00,0,0, "k11_b0"));
        tbl_b.push_back(mk(0,1,1, 1,1,2'b00,0,0, "k11_b1"));
        tbl_b.push_back(mk(0,0,1, 0,1,2'b00,0,0, "k11_par"));
        tbl_b.push_back(mk(0,0,0, 0,0,2'b00,0,0, "k11_e1"));
        tbl_b.push_back(mk(0,0,0, 0,0,2'b11,1,0, "k11_lock"));

        rst_n         = 1'b0;
        load_start    = 1'b0;
        key_bit_in    = 1'b0;
        key_bit_valid = 1'b0;
        #1;
        check("reset_async", 6'b000000);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_held", 6'b000000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", 6'b000000);

        run_table(tbl_a);

        // Reset while LOCKED drops the key immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_in_locked", 6'b000000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset mid-load after one accepted bit.
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start    = 1'b0;
        key_bit_in    = 1'b1;
        key_bit_valid = 1'b1;
        @(posedge clk);
        #1;
        key_bit_valid = 1'b0;
        check("midload_busy", 6'b110000);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_midload", 6'b000000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_rst2", 6'b000000);

        run_table(tbl_b);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
